// File: rtl/route_table_pkg.sv
// Shared types and defaults for the route-table RAM client.
package route_table_pkg;

  localparam int RTC_DEPTH = 16;
  localparam int RTC_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2,
    RSP    = 2'd3
  } rtc_state_e;

  typedef struct packed {
    logic                 err;
    logic [RTC_WIDTH-1:0] dat;
  } rtc_rsp_t;

  // Depth need not be a power of two, so the address field can exceed the table.
  function automatic logic adr_out_of_range(input int unsigned adr, input int unsigned depth);
    return (adr >= depth);
  endfunction

endpackage

// File: rtl/route_client_timer.sv
// Loadable down-counter bounding how long a RAM request may wait for its grant.
import route_table_pkg::*;

module route_client_timer #(
  parameter int MAX_WAIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(MAX_WAIT + 1);

  logic [CW-1:0] cnt_q;

  // Loaded with MAX_WAIT-1 so that zero marks the final permitted request cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else if (load_i) begin
      cnt_q <= CW'(MAX_WAIT - 1);
    end else if (en_i && (cnt_q != {CW{1'b0}})) begin
      cnt_q <= cnt_q - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = (cnt_q == {CW{1'b0}});

endmodule

// File: rtl/route_table_client.sv
// Single-outstanding command engine for one write and one read port of the route-table RAM.
// Optional grant timeout enabled by defining ROUTE_CLIENT_TIMEOUT_EN.
import route_table_pkg::*;

module route_table_client #(
  parameter int D        = RTC_DEPTH,
  parameter int WIDTH    = RTC_WIDTH,
  parameter int LOG_D    = (D > 1) ? $clog2(D) : 1,
  parameter int MAX_WAIT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_write_i,
  input  logic [LOG_D-1:0] cmd_adr_i,
  input  logic [WIDTH-1:0] cmd_dat_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [WIDTH-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  output logic             we_o,
  input  logic             wrRdy_i,
  output logic [LOG_D-1:0] wadr_o,
  output logic [WIDTH-1:0] wdat_o,
  output logic             re_o,
  input  logic             rdRdy_i,
  output logic [LOG_D-1:0] radr_o,
  input  logic [WIDTH-1:0] rdat_i
);

  if (MAX_WAIT < 1) begin : g_max_wait_chk
    $error("route_table_client: MAX_WAIT must be at least 1");
  end

  rtc_state_e       state_q;
  logic             ready_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;
  logic [WIDTH-1:0] rsp_dat_q;
  logic             we_q;
  logic             re_q;
  logic [LOG_D-1:0] wadr_q;
  logic [WIDTH-1:0] wdat_q;
  logic [LOG_D-1:0] radr_q;

  logic accept_s;
  logic oob_s;
  logic timeout_s;

  assign accept_s = cmd_valid_i && ready_q;
  assign oob_s    = adr_out_of_range(32'(cmd_adr_i), unsigned'(D));

`ifdef ROUTE_CLIENT_TIMEOUT_EN
  logic expired_s;

  route_client_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load_i   (accept_s && !oob_s),
    .en_i     ((state_q == WR_REQ) || (state_q == RD_REQ)),
    .expired_o(expired_s)
  );

  assign timeout_s = expired_s;
`else
  assign timeout_s = 1'b0;
`endif

  // Command FSM; every output is a register so nothing on cmd_* reaches the RAM combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= {WIDTH{1'b0}};
      we_q        <= 1'b0;
      re_q        <= 1'b0;
      wadr_q      <= {LOG_D{1'b0}};
      wdat_q      <= {WIDTH{1'b0}};
      radr_q      <= {LOG_D{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept_s) begin
            ready_q <= 1'b0;
            if (oob_s) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_dat_q   <= {WIDTH{1'b0}};
            end else if (cmd_write_i) begin
              state_q <= WR_REQ;
              we_q    <= 1'b1;
              wadr_q  <= cmd_adr_i;
              wdat_q  <= cmd_dat_i;
            end else begin
              state_q <= RD_REQ;
              re_q    <= 1'b1;
              radr_q  <= cmd_adr_i;
            end
          end
        end
        WR_REQ: begin
          // A grant in the final wait cycle takes priority over the timeout.
          if (wrRdy_i || timeout_s) begin
            state_q     <= RSP;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= !wrRdy_i;
            rsp_dat_q   <= {WIDTH{1'b0}};
          end else begin
            state_q <= WR_REQ;
          end
        end
        RD_REQ: begin
          if (rdRdy_i) begin
            state_q     <= RSP;
            re_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= rdat_i;
          end else if (timeout_s) begin
            state_q     <= RSP;
            re_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_dat_q   <= {WIDTH{1'b0}};
          end else begin
            state_q <= RD_REQ;
          end
        end
        RSP: begin
          if (rsp_ready_i) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            ready_q     <= 1'b1;
          end else begin
            state_q <= RSP;
          end
        end
        default: begin
          state_q     <= IDLE;
          ready_q     <= 1'b0;
          rsp_valid_q <= 1'b0;
          we_q        <= 1'b0;
          re_q        <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign we_o        = we_q;
  assign wadr_o      = wadr_q;
  assign wdat_o      = wdat_q;
  assign re_o        = re_q;
  assign radr_o      = radr_q;

endmodule

// File: tb/tb_route_table_client.sv
// Scoreboard bench for route_table_client with a small RAM model (D=12, MAX_WAIT=8).
import route_table_pkg::*;

module tb_route_table_client;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready_o;
  logic        cmd_write = 1'b0;
  logic [3:0]  cmd_adr = 4'd0;
  logic [31:0] cmd_dat = 32'd0;
  logic        rsp_valid_o;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        we_o;
  logic        wr_gnt = 1'b0;
  logic [3:0]  wadr_o;
  logic [31:0] wdat_o;
  logic        re_o;
  logic        rd_gnt = 1'b0;
  logic [3:0]  radr_o;
  logic [31:0] rdat;

  logic [31:0] mem [0:15];
  rtc_rsp_t    exp_q[$];
  int          errors = 0;
  int          checks = 0;

  route_table_client #(.D(12), .WIDTH(32), .MAX_WAIT(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o), .rsp_err_o(rsp_err_o),
    .we_o(we_o), .wrRdy_i(wr_gnt), .wadr_o(wadr_o), .wdat_o(wdat_o),
    .re_o(re_o), .rdRdy_i(rd_gnt), .radr_o(radr_o), .rdat_i(rdat)
  );

  always #5 clk = ~clk;

  // RAM model: preloaded during reset, writes land at the grant edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
    end else if (we_o && wr_gnt) begin
      mem[wadr_o] <= wdat_o;
    end
  end
  assign rdat = mem[radr_o];

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic err, input logic [31:0] dat);
    rtc_rsp_t e;
    e.err = err;
    e.dat = dat;
    exp_q.push_back(e);
  endtask

  // Returns one ns into the cycle after the accepting edge.
  task automatic issue(input logic wr, input logic [3:0] adr, input logic [31:0] dat);
    int n;
    n = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_adr   = adr;
    cmd_dat   = dat;
    @(negedge clk);
    while (!cmd_ready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL issue_wait: cmd_ready_o stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check32("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on every consumed response and checks port exclusivity.
  always @(negedge clk) begin
    rtc_rsp_t e;
    if (!rst) begin
      check1("we_re_excl", we_o & re_o, 1'b0);
      if (rsp_valid_o && rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got err=%0b dat=0x%08h, required no response", rsp_err_o, rsp_dat_o);
        end else begin
          e = exp_q.pop_front();
          check1("rsp_err", rsp_err_o, e.err);
          check32("rsp_dat", rsp_dat_o, e.dat);
        end
      end
    end
  end

  initial begin
    int cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check1("rst_cmd_ready", cmd_ready_o, 1'b0);
    check1("rst_rsp_valid", rsp_valid_o, 1'b0);
    check1("rst_we", we_o, 1'b0);
    check1("rst_re", re_o, 1'b0);
    check1("rst_err", rsp_err_o, 1'b0);
    check32("rst_rsp_dat", rsp_dat_o, 32'd0);
    check32("rst_wadr", {28'd0, wadr_o}, 32'd0);
    check32("rst_wdat", wdat_o, 32'd0);
    check32("rst_radr", {28'd0, radr_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Insert then lookup with grants tied high.
    wr_gnt = 1'b1;
    rd_gnt = 1'b1;
    push_exp(1'b0, 32'h0000_0000);
    issue(1'b1, 4'd3, 32'hA5A5_0003);
    @(negedge clk);
    check1("wr_req_n1", we_o, 1'b1);
    check32("wr_adr_n1", {28'd0, wadr_o}, 32'd3);
    check1("wr_no_rsp_n1", rsp_valid_o, 1'b0);
    @(negedge clk);
    check1("wr_rsp_n2", rsp_valid_o, 1'b1);
    check1("wr_req_drop_n2", we_o, 1'b0);
    @(negedge clk);
    check1("b2b_ready", cmd_ready_o, 1'b1);
    push_exp(1'b0, 32'hA5A5_0003);
    issue(1'b0, 4'd3, 32'd0);
    @(negedge clk);
    check1("rd_req_n1", re_o, 1'b1);
    @(negedge clk);
    check1("rd_rsp_n2", rsp_valid_o, 1'b1);
    drain();

    // Lookup with the grant held off for 7 cycles.
    rd_gnt = 1'b0;
    push_exp(1'b0, 32'hC0DE_0005);
    issue(1'b0, 4'd5, 32'd0);
    cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (re_o && radr_o == 4'd5 && !rsp_valid_o) cnt++;
    end
    @(posedge clk); #1;
    rd_gnt = 1'b1;
    @(negedge clk);
    if (re_o && radr_o == 4'd5 && !rsp_valid_o) cnt++;
    check32("rd_wait_stable_cycles", 32'(cnt), 32'd8);
    @(posedge clk); #1;
    rd_gnt = 1'b0;
    @(negedge clk);
    check1("rd_wait_rsp", rsp_valid_o, 1'b1);
    drain();

    // Response back-pressure.
    rd_gnt = 1'b1;
    rsp_ready = 1'b0;
    push_exp(1'b0, 32'hC0DE_0007);
    issue(1'b0, 4'd7, 32'd0);
    @(negedge clk);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid_o && rsp_dat_o == 32'hC0DE_0007 && !rsp_err_o && !cmd_ready_o) cnt++;
    end
    check32("bp_stable_cycles", 32'(cnt), 32'd4);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Out-of-range addresses never touch the RAM.
    push_exp(1'b1, 32'h0000_0000);
    issue(1'b0, 4'd13, 32'd0);
    @(negedge clk);
    check1("oob_rsp_n1", rsp_valid_o, 1'b1);
    check1("oob_no_re", re_o, 1'b0);
    drain();
    push_exp(1'b1, 32'h0000_0000);
    issue(1'b1, 4'd12, 32'hFFFF_FFFF);
    @(negedge clk);
    check1("oob12_no_we", we_o, 1'b0);
    drain();
    check32("oob12_mem", mem[12], 32'hC0DE_000C);
    push_exp(1'b0, 32'h0000_0000);
    issue(1'b1, 4'd11, 32'h1111_000B);
    push_exp(1'b0, 32'h1111_000B);
    issue(1'b0, 4'd11, 32'd0);
    drain();

`ifdef ROUTE_CLIENT_TIMEOUT_EN
    // Grant never arrives: request lasts MAX_WAIT cycles, then an error response.
    rd_gnt = 1'b0;
    push_exp(1'b1, 32'h0000_0000);
    issue(1'b0, 4'd4, 32'd0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (re_o) cnt++;
    end
    check32("to_req_cycles", 32'(cnt), 32'd8);
    drain();
    // Grant in the last permitted cycle wins.
    push_exp(1'b0, 32'hC0DE_0004);
    issue(1'b0, 4'd4, 32'd0);
    repeat (7) @(negedge clk);
    @(posedge clk); #1;
    rd_gnt = 1'b1;
    @(negedge clk);
    check1("to_last_req", re_o, 1'b1);
    @(posedge clk); #1;
    rd_gnt = 1'b0;
    @(negedge clk);
    check1("to_last_rsp", rsp_valid_o, 1'b1);
    drain();
`endif

    // Reset while waiting for a read grant, with the grant coincident with reset.
    rd_gnt = 1'b0;
    issue(1'b0, 4'd6, 32'd0);
    @(negedge clk);
    check1("rst_mid_req", re_o, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    rd_gnt = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_gnt = 1'b0;
    @(negedge clk);
    check1("rst_mid_re", re_o, 1'b0);
    check1("rst_mid_rsp", rsp_valid_o, 1'b0);
    check1("rst_mid_ready", cmd_ready_o, 1'b0);
    rd_gnt = 1'b1;
    push_exp(1'b0, 32'hC0DE_0002);
    issue(1'b0, 4'd2, 32'd0);
    drain();
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
